// File: rtl/popcnt_sched.sv
// popcnt_sched -- shared bit-serial popcount engine with a round-robin front end.
//
// NREQ clients present WIDTH-bit words over valid/ready. A round-robin arbiter
// grants one client while the engine is idle; the granted word is then counted
// one bit per clock and the result is returned, tagged with the client ID, on a
// valid/ready response channel.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   req_valid  [NREQ]        per-client request valid
//   req_data   [NREQ*WIDTH]  client i word at bits [i*WIDTH +: WIDTH]
//   req_ready  [NREQ]        one-hot grant (combinational, IDLE only)
//   rsp_valid  result available (RESP state)
//   rsp_ready  consumer accepts result
//   rsp_id     [ID_W]        index of the client whose word was counted
//   rsp_count  [CNT_W]       number of set bits in that word
//   busy       high in COUNT and RESP
//
// Build option: define POPCNT_EARLY_EXIT_EN to end COUNT as soon as the
// remaining shifted word is zero (same results, data-dependent latency).
// Without it COUNT always lasts exactly WIDTH cycles.

module popcnt_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int ID_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [CNT_W-1:0]        rsp_count,
    output logic                    busy
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [WIDTH-1:0]   words [NREQ];
    logic [ID_W-1:0]    grant_id;
    logic               grant_found;
    int                 rr_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_client
            assign words[gi]     = req_data[gi*WIDTH +: WIDTH];
            assign req_ready[gi] = (state_q == IDLE) && grant_found &&
                                   (grant_id == ID_W'(gi));
        end
    endgenerate

    // Round-robin search starting at last_grant+1. Walking the offsets from
    // farthest to nearest lets the nearest valid client overwrite the others.
    always_comb begin
        grant_id    = '0;
        grant_found = 1'b0;
        rr_idx      = 0;
        for (int off = NREQ; off >= 1; off--) begin
            rr_idx = int'(last_grant_q) + off;
            if (rr_idx >= NREQ) begin
                rr_idx = rr_idx - NREQ;
            end
            if (req_valid[rr_idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        shreg_d      = shreg_q;
        count_d      = count_q;
        idx_d        = idx_q;
        case (state_q)
            IDLE: begin
                // req_ready is only ever raised on a valid client, so a grant
                // is the handshake.
                if (grant_found) begin
                    shreg_d      = words[grant_id];
                    id_d         = grant_id;
                    count_d      = '0;
                    idx_d        = '0;
                    last_grant_d = grant_id;
                    state_d      = COUNT;
                end
            end
            COUNT: begin
                count_d = count_q + CNT_W'(shreg_q[0]);
                shreg_d = shreg_q >> 1;
                idx_d   = idx_q + 1'b1;
`ifdef POPCNT_EARLY_EXIT_EN
                if ((idx_q == IDX_W'(WIDTH - 1)) || (shreg_d == '0)) begin
                    state_d = RESP;
                end
`else
                if (idx_q == IDX_W'(WIDTH - 1)) begin
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NREQ - 1);
            id_q         <= '0;
            shreg_q      <= '0;
            count_q      <= '0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            shreg_q      <= shreg_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = id_q;
    assign rsp_count = count_q;

endmodule

// File: tb/tb_popcnt_sched.sv
// Testbench for popcnt_sched: scoreboard of expected {id, count, latency}
// pushed at each accept handshake and compared when a response appears.
module tb_popcnt_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int CNT_W = 5;
    localparam int ID_W  = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [CNT_W-1:0]      rsp_count;
    logic                  busy;

    popcnt_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int cnt;
        int lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   last_acc;
    bit   ok;
    int   gid, gcnt, glat;

    // Cycles spent in COUNT for a word.
    function automatic int exp_lat(logic [WIDTH-1:0] w);
`ifdef POPCNT_EARLY_EXIT_EN
        int m = 0;
        for (int i = 0; i < WIDTH; i++) if (w[i]) m = i + 1;
        return (m < 1) ? 1 : m;
`else
        return WIDTH;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Present a word from client id and wait (bounded) for its accept edge.
    task automatic do_accept(input int id, input logic [WIDTH-1:0] w, output bit acc_ok);
        req_data[id*WIDTH +: WIDTH] = w;
        req_valid[id] = 1'b1;
        acc_ok = 1'b0;
        for (int n = 0; n < 100 && !acc_ok; n++) begin
            #1;
            if (req_ready[id]) begin
                @(posedge clk);
                #1;
                acc_ok   = 1'b1;
                last_acc = cyc;
                sb.push_back('{id, $countones(w), exp_lat(w)});
                $display("accept id=%0d data=%h at cycle %0d", id, w, cyc);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        req_valid[id] = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid; capture it; complete handshake if rsp_ready.
    task automatic wait_rsp(output bit r_ok, output int r_id, output int r_cnt, output int r_lat);
        r_ok = 1'b0; r_id = -1; r_cnt = -1; r_lat = -1;
        for (int n = 0; n < 200 && !r_ok; n++) begin
            if (rsp_valid) begin
                r_ok  = 1'b1;
                r_id  = int'(rsp_id);
                r_cnt = int'(rsp_count);
                r_lat = cyc - last_acc;
            end else begin
                tick();
            end
        end
        if (r_ok) $display("response id=%0d count=%0d latency=%0d", r_id, r_cnt, r_lat);
        if (r_ok && rsp_ready) tick();
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 ||
            rsp_count !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b id=%0d count=%0d busy=%b, expected all zero",
                     req_ready, rsp_valid, rsp_id, rsp_count, busy);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_all_ones;
        do_reset();
        rsp_ready = 1'b1;
        do_accept(0, 16'hFFFF, ok);
        wait_rsp(ok, gid, gcnt, glat);
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++;
            $display("FAIL all_ones: no response (timeout), expected id=0 count=16");
        end else begin
            e = sb.pop_front();
            if (gid !== e.id || gcnt !== e.cnt || glat !== e.lat) begin
                errors++;
                $display("FAIL all_ones: got id=%0d count=%0d lat=%0d, expected id=%0d count=%0d lat=%0d",
                         gid, gcnt, glat, e.id, e.cnt, e.lat);
            end
        end
        checks++;
        if (gcnt !== 16 || glat !== 16) begin
            errors++;
            $display("FAIL all_ones_const: got count=%0d lat=%0d, expected count=16 lat=16", gcnt, glat);
        end
    endtask

    task automatic test_client2;
        logic [WIDTH-1:0] words [2];
        words[0] = 16'h0000;
        words[1] = 16'hA5A5;
        rsp_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            do_accept(2, words[j], ok);
            wait_rsp(ok, gid, gcnt, glat);
            checks++;
            if (!ok || sb.size() == 0) begin
                errors++;
                $display("FAIL client2_%0d: no response (timeout)", j);
                sb.delete();
            end else begin
                e = sb.pop_front();
                if (gid !== e.id || gcnt !== e.cnt || glat !== e.lat) begin
                    errors++;
                    $display("FAIL client2_%0d: got id=%0d count=%0d lat=%0d, expected id=%0d count=%0d lat=%0d",
                             j, gid, gcnt, glat, e.id, e.cnt, e.lat);
                end
            end
        end
    endtask

    task automatic test_round_robin;
        logic [WIDTH-1:0] words [NREQ];
        bit onehot_bad = 1'b0;
        bit got;
        int exp_id;
        words[0] = 16'h0003;
        words[1] = 16'h001F;
        words[2] = 16'h0FFF;
        words[3] = 16'h7FFF;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = words[i];
        req_valid = '1;
        for (int j = 0; j < 5; j++) begin
            exp_id = j % NREQ;
            got = 1'b0;
            for (int n = 0; n < 50 && !got; n++) begin
                #1;
                if ($countones(req_ready) > 1) onehot_bad = 1'b1;
                if (req_ready != '0) got = 1'b1;
                else tick();
            end
            checks++;
            if (req_ready !== NREQ'(1 << exp_id)) begin
                errors++;
                $display("FAIL rr_grant_%0d: req_ready=%b, expected %b", j, req_ready, NREQ'(1 << exp_id));
            end
            @(posedge clk);
            #1;
            last_acc = cyc;
            sb.push_back('{exp_id, $countones(words[exp_id]), exp_lat(words[exp_id])});
            if (j == 4) req_valid = '0;
            for (int n = 0; n < 40; n++) begin
                if (!rsp_valid && $countones(req_ready) > 1) onehot_bad = 1'b1;
            end
            wait_rsp(ok, gid, gcnt, glat);
            checks++;
            if (!ok || sb.size() == 0) begin
                errors++;
                $display("FAIL rr_rsp_%0d: no response (timeout)", j);
                sb.delete();
            end else begin
                e = sb.pop_front();
                if (gid !== e.id || gcnt !== e.cnt || glat !== e.lat) begin
                    errors++;
                    $display("FAIL rr_rsp_%0d: got id=%0d count=%0d lat=%0d, expected id=%0d count=%0d lat=%0d",
                             j, gid, gcnt, glat, e.id, e.cnt, e.lat);
                end
            end
        end
        checks++;
        if (onehot_bad) begin
            errors++;
            $display("FAIL rr_onehot: req_ready had more than one bit set, expected at most one");
        end
    endtask

    task automatic test_backpressure;
        int hcyc;
        do_reset();
        rsp_ready = 1'b0;
        do_accept(1, 16'h00F0, ok);
        wait_rsp(ok, gid, gcnt, glat);
        e = '{-1, -1, -1};
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++;
            $display("FAIL bp_rsp: no response (timeout), expected id=1 count=4");
            sb.delete();
        end else begin
            e = sb.pop_front();
            if (gid !== e.id || gcnt !== e.cnt || glat !== e.lat || gcnt !== 4) begin
                errors++;
                $display("FAIL bp_rsp: got id=%0d count=%0d lat=%0d, expected id=%0d count=%0d lat=%0d",
                         gid, gcnt, glat, e.id, e.cnt, e.lat);
            end
        end
        req_data[2*WIDTH +: WIDTH] = 16'h0101;
        req_valid[2] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || int'(rsp_id) !== e.id || int'(rsp_count) !== e.cnt || req_ready !== 4'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b id=%0d count=%0d ready=%b, expected valid=1 id=%0d count=%0d ready=0000",
                         n, rsp_valid, rsp_id, rsp_count, req_ready, e.id, e.cnt);
            end
        end
        rsp_ready = 1'b1;
        tick();
        hcyc = cyc;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b, expected valid=0 ready=0100", rsp_valid, req_ready);
        end
        do_accept(2, 16'h0101, ok);
        checks++;
        if (!ok || last_acc - hcyc !== 1) begin
            errors++;
            $display("FAIL bp_next_grant: accept %0d cycles after handshake, expected 1", last_acc - hcyc);
        end
        wait_rsp(ok, gid, gcnt, glat);
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++;
            $display("FAIL bp_next_rsp: no response (timeout)");
            sb.delete();
        end else begin
            e = sb.pop_front();
            if (gid !== e.id || gcnt !== e.cnt || glat !== e.lat) begin
                errors++;
                $display("FAIL bp_next_rsp: got id=%0d count=%0d lat=%0d, expected id=%0d count=%0d lat=%0d",
                         gid, gcnt, glat, e.id, e.cnt, e.lat);
            end
        end
    endtask

    task automatic test_reset_mid_count;
        bit spurious = 1'b0;
        do_reset();
        rsp_ready = 1'b1;
        do_accept(1, 16'hFFFF, ok);
        for (int n = 0; n < 7; n++) tick();
        reset = 1'b1;
        tick();
        sb.delete();
        checks++;
        if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 ||
            rsp_count !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: ready=%b valid=%b id=%0d count=%0d busy=%b, expected all zero",
                     req_ready, rsp_valid, rsp_id, rsp_count, busy);
        end
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (rsp_valid) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL mid_reset_norsp: rsp_valid=1 seen after reset, expected 0");
        end
        req_data[0*WIDTH +: WIDTH] = 16'h0007;
        req_data[1*WIDTH +: WIDTH] = 16'h0300;
        req_valid = 4'b0011;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_reset_prio: req_ready=%b, expected 0001", req_ready);
        end
        for (int c = 0; c < 2; c++) begin
            do_accept(c, (c == 0) ? 16'h0007 : 16'h0300, ok);
            wait_rsp(ok, gid, gcnt, glat);
            checks++;
            if (!ok || sb.size() == 0) begin
                errors++;
                $display("FAIL mid_reset_rsp_%0d: no response (timeout)", c);
                sb.delete();
            end else begin
                e = sb.pop_front();
                if (gid !== e.id || gcnt !== e.cnt || glat !== e.lat) begin
                    errors++;
                    $display("FAIL mid_reset_rsp_%0d: got id=%0d count=%0d lat=%0d, expected id=%0d count=%0d lat=%0d",
                             c, gid, gcnt, glat, e.id, e.cnt, e.lat);
                end
            end
        end
    endtask

    task automatic test_single_bit;
        int exp_l;
`ifdef POPCNT_EARLY_EXIT_EN
        exp_l = 1;
`else
        exp_l = 16;
`endif
        rsp_ready = 1'b1;
        do_accept(3, 16'h0001, ok);
        wait_rsp(ok, gid, gcnt, glat);
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++;
            $display("FAIL single_bit: no response (timeout)");
            sb.delete();
        end else begin
            e = sb.pop_front();
            if (gid !== 3 || gcnt !== 1 || glat !== exp_l || glat !== e.lat) begin
                errors++;
                $display("FAIL single_bit: got id=%0d count=%0d lat=%0d, expected id=3 count=1 lat=%0d",
                         gid, gcnt, glat, exp_l);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_client2();
        test_round_robin();
        test_backpressure();
        test_reset_mid_count();
        test_single_bit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
